// File: rtl/bayer_window_loader_pkg.sv
// Shared types and constants for the Bayer 5x5 window loader.
// Window geometry, FSM encoding and Bayer region codes.
package bayer_window_loader_pkg;

    localparam int WIN_BYTES  = 25;
    localparam int WIN_BITS   = 200;
    localparam int ROW_STRIDE = 40;

    typedef enum logic [1:0] {
        ST_ACCEPT    = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_RELEASE   = 2'd2
    } state_e;

    localparam logic [1:0] REG_GR = 2'b00;
    localparam logic [1:0] REG_R  = 2'b01;
    localparam logic [1:0] REG_B  = 2'b10;
    localparam logic [1:0] REG_GB = 2'b11;

    function automatic logic [1:0] region_of(
        input logic       cy0,
        input logic       cx0,
        input logic [1:0] phase
    );
        logic [1:0] base;
        unique case ({cy0, cx0})
            2'b00:   base = REG_GR;
            2'b01:   base = REG_R;
            2'b10:   base = REG_B;
            default: base = REG_GB;
        endcase
        return base ^ phase;
    endfunction

endpackage

// File: rtl/bayer_window_loader_line_buffer_bank.sv
// Four cascaded line memories sharing one column address.
// An accept reads all four lines, then shifts the column down one line.
module line_buffer_bank #(
    parameter  int IMG_W = 320,
    localparam int AW    = $clog2(IMG_W)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr,
    input  logic [7:0]      i_din,
    output logic [3:0][7:0] o_rd
);

    logic [7:0] r_mem [4][IMG_W];

    always_comb begin
        for (int k = 0; k < 4; k++)
            o_rd[k] = r_mem[k][i_addr];
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[0][i_addr] <= i_din;
            for (int k = 1; k < 4; k++)
                r_mem[k][i_addr] <= r_mem[k-1][i_addr];
        end
    end

endmodule

// File: rtl/bayer_window_loader.sv
// Raster Bayer stream to 5x5 window feeder for the ULA stage.
// One window is presented at a time under a start/done handshake.
module bayer_window_loader
    import bayer_window_loader_pkg::*;
#(
    parameter  int         IMG_W       = 320,
    parameter  int         IMG_H       = 240,
    parameter  logic [1:0] BAYER_PHASE = 2'b00,
    localparam int         XW          = $clog2(IMG_W),
    localparam int         YW          = $clog2(IMG_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_valid,
    input  logic [7:0]          pix_in,
    output logic                pix_ready,
    output logic [WIN_BITS-1:0] matriz_a,
    output logic [1:0]          pixel_region,
    output logic                start,
    input  logic                done,
    output logic [XW-1:0]       win_x,
    output logic [YW-1:0]       win_y,
    output logic                frame_done
);

    state_e                r_state;
    state_e                w_next;
    logic                  r_run;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [WIN_BITS-1:0]   r_win;
    logic [WIN_BITS-1:0]   w_win_nx;
    logic [3:0][7:0]       w_rd;
    logic [4:0][7:0]       w_col;
    logic [XW-1:0]         w_cx;
    logic [YW-1:0]         w_cy;
    logic [XW-1:0]         r_win_x;
    logic [YW-1:0]         r_win_y;
    logic [1:0]            r_region;
    logic                  r_last;
    logic                  r_fd_nowin;
    logic                  w_acc;
    logic                  w_xend;
    logic                  w_last;
    logic                  w_complete;

    line_buffer_bank #(.IMG_W(IMG_W)) u_lb (
        .clk    (clk),
        .i_we   (w_acc),
        .i_addr (r_x),
        .i_din  (pix_in),
        .o_rd   (w_rd)
    );

    assign w_acc      = pix_valid && pix_ready;
    assign w_xend     = (r_x == XW'(IMG_W - 1));
    assign w_last     = w_xend && (r_y == YW'(IMG_H - 1));
    assign w_complete = w_acc && (r_x >= XW'(4)) && (r_y >= YW'(4));
    assign w_cx       = r_x - XW'(2);
    assign w_cy       = r_y - YW'(2);
    // Oldest line (LB3) lands in row 0, the live pixel in row 4
    assign w_col      = {pix_in, w_rd[0], w_rd[1], w_rd[2], w_rd[3]};

    always_comb begin
        w_win_nx = r_win;
        for (int b = 0; b < WIN_BYTES; b++) begin
            if (b % 5 == 4)
                w_win_nx[(b/5)*ROW_STRIDE + 32 +: 8] = w_col[b/5];
            else
                w_win_nx[(b/5)*ROW_STRIDE + (b%5)*8 +: 8] =
                    r_win[(b/5)*ROW_STRIDE + (b%5)*8 + 8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_win <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                r_win <= w_win_nx;
                if (w_xend) begin
                    r_x <= '0;
                    r_y <= w_last ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_x    <= '0;
            r_win_y    <= '0;
            r_region   <= '0;
            r_last     <= 1'b0;
            r_fd_nowin <= 1'b0;
        end else begin
            r_fd_nowin <= w_acc && w_last && !w_complete;
            if (w_complete) begin
                r_win_x  <= w_cx;
                r_win_y  <= w_cy;
                r_region <= region_of(w_cy[0], w_cx[0], BAYER_PHASE);
                r_last   <= w_last;
            end else if (r_state == ST_RELEASE) begin
                r_last   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_ACCEPT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_ACCEPT:    if (w_complete) w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done) w_next = ST_RELEASE;
            ST_RELEASE:   w_next = ST_ACCEPT;
            default:      w_next = ST_ACCEPT;
        endcase
    end

    always_comb begin
        pix_ready    = r_run && (r_state == ST_ACCEPT);
        start        = (r_state == ST_WAIT_DONE);
        frame_done   = r_fd_nowin || ((r_state == ST_RELEASE) && r_last);
        matriz_a     = r_win;
        pixel_region = r_region;
        win_x        = r_win_x;
        win_y        = r_win_y;
    end

endmodule

// File: tb/tb_bayer_window_loader.sv
// Directed bench for bayer_window_loader on an 8x6 frame.
// A second instance with BAYER_PHASE=11 shares all stimulus.
module tb_bayer_window_loader;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NW = (W - 4) * (H - 4);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pix_valid;
    logic [7:0]   pix_in;
    logic         pix_ready, pix_ready2;
    logic [199:0] mat, mat2;
    logic [1:0]   reg0, reg1;
    logic         start, start2;
    logic         done;
    logic [2:0]   wx, wx2, wy, wy2;
    logic         fd, fd2;

    logic done_m   = 1'b0;
    logic done_inj = 1'b0;
    assign done = done_m | done_inj;

    bayer_window_loader #(.IMG_W(W), .IMG_H(H), .BAYER_PHASE(2'b00)) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(pix_ready), .matriz_a(mat), .pixel_region(reg0),
        .start(start), .done(done), .win_x(wx), .win_y(wy),
        .frame_done(fd)
    );

    bayer_window_loader #(.IMG_W(W), .IMG_H(H), .BAYER_PHASE(2'b11)) u_ph3 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(pix_ready2), .matriz_a(mat2), .pixel_region(reg1),
        .start(start2), .done(done), .win_x(wx2), .win_y(wy2),
        .frame_done(fd2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ula_delay = 5;
    int ucnt = 0;
    int nacc = 0;
    bit abort = 1'b0;

    // ULA model: done rises ula_delay clocks after start, drops with start
    always @(negedge clk) begin
        if (start) begin
            ucnt++;
            if (ucnt >= ula_delay) done_m = 1'b1;
        end else begin
            ucnt = 0;
            done_m = 1'b0;
        end
    end

    logic [199:0] cap_mat [64];
    int           cap_x   [64];
    int           cap_y   [64];
    logic [1:0]   cap_r0  [64];
    logic [1:0]   cap_r1  [64];
    int           cap_acc [64];
    int           cap_len [64];
    int nwin = 0, nfd = 0, hold_err = 0, pair_err = 0, cur_len = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (start && !prev_start) begin
            if (nwin < 64) begin
                cap_mat[nwin] = mat;
                cap_x[nwin]   = int'(wx);
                cap_y[nwin]   = int'(wy);
                cap_r0[nwin]  = reg0;
                cap_r1[nwin]  = reg1;
                cap_acc[nwin] = nacc;
                cap_len[nwin] = 0;
            end
            nwin++;
            cur_len = 0;
        end
        if (start) begin
            cur_len++;
            if (nwin > 0 && nwin <= 64)
                if (mat !== cap_mat[nwin-1] || int'(wx) != cap_x[nwin-1] ||
                    int'(wy) != cap_y[nwin-1] || reg0 !== cap_r0[nwin-1] ||
                    pix_ready !== 1'b0)
                    hold_err++;
        end
        if (!start && prev_start && nwin > 0 && nwin <= 64)
            cap_len[nwin-1] = cur_len;
        if (fd) nfd++;
        if ({mat2, wx2, wy2, start2, pix_ready2, fd2} !==
            {mat, wx, wy, start, pix_ready, fd})
            pair_err++;
        prev_start = start;
    end

    function automatic logic [7:0] pixval(input int base, input int x, input int y);
        return 8'((base + W * y + x) & 255);
    endfunction

    function automatic logic [199:0] exp_win(input int base, input int cx, input int cy);
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[r*40 + c*8 +: 8] = pixval(base, cx - 2 + c, cy - 2 + r);
        return m;
    endfunction

    task automatic feed_frame(input int base, input int gap, input bit inj, output bit ok);
        int x = 0, y = 0, budget = 0;
        bit acc;
        nacc = 0;
        ok = 1'b1;
        while (y < H) begin
            @(negedge clk);
            if (abort) return;
            pix_valid = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
            pix_in    = pixval(base, x, y);
            done_inj  = inj && (y < 4) && (budget % 2 == 1);
            acc       = pix_valid && pix_ready;
            @(posedge clk);
            if (acc) begin
                nacc++;
                x++;
                if (x == W) begin x = 0; y++; end
            end
            budget++;
            if (budget > 20000) begin ok = 1'b0; return; end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        done_inj  = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        int n = 0;
        while (nfd < target && n < 500) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        tests++;
        if (nfd < target) begin
            fails++;
            $display("FAIL wait_frame_done: got %0d pulses, need %0d", nfd, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if ({pix_ready, start, fd} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: ready/start/fd=%b need 000", {pix_ready, start, fd});
        end
        tests++;
        if (mat !== '0) begin
            fails++; $display("FAIL reset_matriz: %h need 0", mat);
        end
        tests++;
        if ({reg0, wx, wy} !== 8'h00) begin
            fails++; $display("FAIL reset_meta: %h need 00", {reg0, wx, wy});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (pix_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_reset: %b need 1", pix_ready);
        end
    endtask

    task automatic test_frame();
        int n0 = nwin, f0 = nfd, p0 = pair_err;
        bit ok;
        int ks [4] = '{0, 1, 4, 5};
        logic [1:0] e0 [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] e1 [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
        ula_delay = 5;
        feed_frame(0, 0, 1'b1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL frame_feed: timeout"); end
        wait_fd(f0 + 1);
        tests++;
        if (nwin - n0 != NW) begin
            fails++; $display("FAIL frame_starts: %0d need %0d", nwin - n0, NW);
        end
        tests++;
        if (cap_acc[n0] != 37) begin
            fails++; $display("FAIL fill_no_start: first start after %0d accepts need 37", cap_acc[n0]);
        end
        tests++;
        if (cap_x[n0] != 2 || cap_y[n0] != 2) begin
            fails++; $display("FAIL first_centre: (%0d,%0d) need (2,2)", cap_x[n0], cap_y[n0]);
        end
        tests++;
        if (cap_mat[n0][0+:8] !== 8'd0 || cap_mat[n0][48+:8] !== 8'd9 ||
            cap_mat[n0][96+:8] !== 8'd18) begin
            fails++;
            $display("FAIL first_elems: %0d %0d %0d need 0 9 18", cap_mat[n0][0+:8],
                     cap_mat[n0][48+:8], cap_mat[n0][96+:8]);
        end
        tests++;
        if (cap_len[n0] != 5) begin
            fails++; $display("FAIL start_len: %0d need 5", cap_len[n0]);
        end
        for (int k = 0; k < NW; k++) begin
            tests++;
            if (cap_mat[n0+k] !== exp_win(0, 2 + k % 4, 2 + k / 4) ||
                cap_x[n0+k] != 2 + k % 4 || cap_y[n0+k] != 2 + k / 4) begin
                fails++;
                $display("FAIL frame_win%0d: (%0d,%0d) %h need %h", k, cap_x[n0+k],
                         cap_y[n0+k], cap_mat[n0+k], exp_win(0, 2 + k % 4, 2 + k / 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cap_r0[n0+ks[i]] !== e0[i] || cap_r1[n0+ks[i]] !== e1[i]) begin
                fails++;
                $display("FAIL region_win%0d: %b/%b need %b/%b", ks[i],
                         cap_r0[n0+ks[i]], cap_r1[n0+ks[i]], e0[i], e1[i]);
            end
        end
        tests++;
        if (nfd - f0 != 1) begin
            fails++; $display("FAIL frame_done_count: %0d need 1", nfd - f0);
        end
        tests++;
        if (pair_err != p0) begin
            fails++; $display("FAIL phase_pair: %0d diffs need 0", pair_err - p0);
        end
    endtask

    task automatic test_stall();
        int n0 = nwin, f0 = nfd, h0 = hold_err, mn = 1000;
        bit ok;
        ula_delay = 50;
        feed_frame(50, 0, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL stall_feed: timeout"); end
        wait_fd(f0 + 1);
        tests++;
        if (nwin - n0 != NW) begin
            fails++; $display("FAIL stall_starts: %0d need %0d", nwin - n0, NW);
        end
        tests++;
        if (hold_err != h0) begin
            fails++; $display("FAIL stall_hold: %0d violations need 0", hold_err - h0);
        end
        for (int k = 0; k < NW; k++) if (cap_len[n0+k] < mn) mn = cap_len[n0+k];
        tests++;
        if (mn < 50) begin
            fails++; $display("FAIL stall_len: min start length %0d need >=50", mn);
        end
        for (int k = 0; k < NW; k++) begin
            tests++;
            if (cap_mat[n0+k] !== exp_win(50, 2 + k % 4, 2 + k / 4)) begin
                fails++;
                $display("FAIL stall_win%0d: %h need %h", k, cap_mat[n0+k],
                         exp_win(50, 2 + k % 4, 2 + k / 4));
            end
        end
        ula_delay = 5;
    endtask

    task automatic test_reset_mid();
        int n0, f0, n = 0;
        bit ok;
        ula_delay = 1000;
        abort = 1'b0;
        fork
            feed_frame(7, 0, 1'b0, ok);
            begin
                while (!start && n < 300) begin @(negedge clk); n++; end
                tests++;
                if (!start) begin fails++; $display("FAIL mid_no_start: start=%b need 1", start); end
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                tests++;
                if (start !== 1'b0 || pix_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL mid_async: start=%b ready=%b need 0 0", start, pix_ready);
                end
                abort = 1'b1;
            end
        join
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        ula_delay = 5;
        @(negedge clk);
        n0 = nwin; f0 = nfd;
        feed_frame(30, 0, 1'b0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL mid_feed: timeout"); end
        wait_fd(f0 + 1);
        tests++;
        if (nwin - n0 != NW || cap_x[n0] != 2 || cap_y[n0] != 2) begin
            fails++;
            $display("FAIL mid_restart: %0d windows first (%0d,%0d) need %0d (2,2)",
                     nwin - n0, cap_x[n0], cap_y[n0], NW);
        end
        for (int k = 0; k < NW; k++) begin
            tests++;
            if (cap_mat[n0+k] !== exp_win(30, 2 + k % 4, 2 + k / 4)) begin
                fails++;
                $display("FAIL mid_win%0d: %h need %h", k, cap_mat[n0+k],
                         exp_win(30, 2 + k % 4, 2 + k / 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0 = nwin, f0 = nfd;
        bit ok1, ok2;
        ula_delay = 3;
        feed_frame(100, 30, 1'b0, ok1);
        feed_frame(200, 30, 1'b0, ok2);
        tests++;
        if (!ok1 || !ok2) begin fails++; $display("FAIL b2b_feed: timeout %b%b", ok1, ok2); end
        wait_fd(f0 + 2);
        tests++;
        if (nwin - n0 != 2 * NW) begin
            fails++; $display("FAIL b2b_starts: %0d need %0d", nwin - n0, 2 * NW);
        end
        tests++;
        if (nfd - f0 != 2) begin
            fails++; $display("FAIL b2b_frame_done: %0d need 2", nfd - f0);
        end
        for (int k = 0; k < 2 * NW; k++) begin
            tests++;
            if (cap_mat[n0+k] !== exp_win(k < NW ? 100 : 200, 2 + (k % NW) % 4, 2 + (k % NW) / 4)) begin
                fails++;
                $display("FAIL b2b_win%0d: %h need %h", k, cap_mat[n0+k],
                         exp_win(k < NW ? 100 : 200, 2 + (k % NW) % 4, 2 + (k % NW) / 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
